// File: rtl/prbs_chk_itu_o150.sv
// Parallel PRBS9 (x^9+x^5+1) checker: self-syncs, locks, counts bit errors.
// Optional input inversion (port iinv) when PRBS_CHK_INV_EN is defined.
module prbs_chk_itu_o150 #(
  parameter int DATW   = 64,
  parameter int STA0   = 9,
  parameter int TAP    = 5,
  parameter int LCK_N  = 4,
  parameter int ULK_N  = 4,
  parameter int BAD_TH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       ivld,
  input  logic [DATW-1:0]            idat,
`ifdef PRBS_CHK_INV_EN
  input  logic                       iinv,
`endif
  input  logic                       iclr,
  output logic                       olock,
  output logic                       oerr_beat,
  output logic [$clog2(DATW+1)-1:0]  oerr_num,
  output logic [31:0]                oerr_cnt
);

  localparam int NW = $clog2(DATW+1);
  localparam int CW = $clog2(LCK_N+1);
  localparam int UW = $clog2(ULK_N+1);

  localparam logic [1:0] S_HUNT = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  logic [1:0]      st_q, st_d;
  logic [STA0-1:0] ref_q, ref_d;
  logic [CW-1:0]   cln_q, cln_d;
  logic [UW-1:0]   bad_q, bad_d;
  logic            olock_q, olock_d;
  logic            oerr_beat_q, oerr_beat_d;
  logic [NW-1:0]   oerr_num_q, oerr_num_d;
  logic [31:0]     oerr_cnt_q, oerr_cnt_d;

  logic [DATW-1:0]      d;
  logic [DATW-1:0]      e;
  logic [DATW-1:0]      x;
  logic [STA0+DATW-1:0] w;
  logic [NW-1:0]        errn;
  logic [STA0-1:0]      seed;
  logic [STA0-1:0]      adv;
  logic                 seed_ok;
  logic                 bad_bt;
  logic [32:0]          sum;

  // received data, optionally inverted
  always_comb begin
`ifdef PRBS_CHK_INV_EN
    d = iinv ? ~idat : idat;
`else
    d = idat;
`endif
  end

  // expected beat unrolled from ref; ref[STA0-1] is the latest bit
  always_comb begin
    w = '0;
    w[STA0-1:0] = ref_q;
    for (int i = 0; i < DATW; i++) begin
      w[STA0+i] = w[i] ^ w[STA0+i-TAP];
    end
    e = w[STA0+DATW-1:STA0];
    x = d ^ e;
    errn = '0;
    for (int i = 0; i < DATW; i++) begin
      errn = errn + NW'(x[i]);
    end
    seed    = d[DATW-1:DATW-STA0];
    adv     = e[DATW-1:DATW-STA0];
    seed_ok = |seed;
    bad_bt  = errn >= NW'(BAD_TH);
    sum     = {1'b0, oerr_cnt_q} + 33'(errn);
  end

  // sync state machine and error accounting
  always_comb begin
    st_d        = st_q;
    ref_d       = ref_q;
    cln_d       = cln_q;
    bad_d       = bad_q;
    oerr_beat_d = 1'b0;
    oerr_num_d  = oerr_num_q;
    oerr_cnt_d  = oerr_cnt_q;
    if (ivld) begin
      unique case (1'b1)
        (st_q == S_HUNT): begin
          if (seed_ok) begin
            ref_d = seed;
            cln_d = '0;
            st_d  = S_SYNC;
          end
        end
        (st_q == S_SYNC): begin
          if (errn == '0) begin
            ref_d = adv;
            if (cln_q == CW'(LCK_N-1)) begin
              cln_d = '0;
              bad_d = '0;
              st_d  = S_LOCK;
            end else begin
              cln_d = cln_q + 1'b1;
            end
          end else if (seed_ok) begin
            ref_d = seed;
            cln_d = '0;
          end else begin
            cln_d = '0;
            st_d  = S_HUNT;
          end
        end
        (st_q == S_LOCK): begin
          ref_d       = adv;
          oerr_num_d  = errn;
          oerr_beat_d = errn != '0;
          oerr_cnt_d  = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
          if (bad_bt) begin
            if (bad_q == UW'(ULK_N-1)) begin
              bad_d = '0;
              st_d  = S_HUNT;
            end else begin
              bad_d = bad_q + 1'b1;
            end
          end else begin
            bad_d = '0;
          end
        end
        default: st_d = S_HUNT;
      endcase
    end
    if (iclr) begin
      oerr_cnt_d = '0;
    end
    olock_d = st_d == S_LOCK;
  end

  // state and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q        <= S_HUNT;
      ref_q       <= '0;
      cln_q       <= '0;
      bad_q       <= '0;
      olock_q     <= 1'b0;
      oerr_beat_q <= 1'b0;
      oerr_num_q  <= '0;
      oerr_cnt_q  <= '0;
    end else begin
      st_q        <= st_d;
      ref_q       <= ref_d;
      cln_q       <= cln_d;
      bad_q       <= bad_d;
      olock_q     <= olock_d;
      oerr_beat_q <= oerr_beat_d;
      oerr_num_q  <= oerr_num_d;
      oerr_cnt_q  <= oerr_cnt_d;
    end
  end

  assign olock     = olock_q;
  assign oerr_beat = oerr_beat_q;
  assign oerr_num  = oerr_num_q;
  assign oerr_cnt  = oerr_cnt_q;

endmodule

// File: tb/tb_prbs_chk_itu_o150.sv
// Bench for prbs_chk_itu_o150: vector table plus directed sequences.
// Inversion checks are built when PRBS_CHK_INV_EN is defined.
module tb_prbs_chk_itu_o150;

  localparam int HOLD = -2;
  localparam int REF  = -1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ivld;
  logic [63:0] idat;
  logic        iclr;
`ifdef PRBS_CHK_INV_EN
  logic        iinv;
`endif
  logic        olock;
  logic        oerr_beat;
  logic [6:0]  oerr_num;
  logic [31:0] oerr_cnt;

  int total = 0;
  int bad   = 0;

  logic [8:0] hist;

  typedef struct {
    bit          vld;
    bit          zero;
    logic [63:0] flip;
    bit          clr;
    bit          add;
    bit          e_lock;
    bit          e_beat;
    int          e_num;
  } vec_t;

  vec_t tv[30];

  prbs_chk_itu_o150 dut (
    .clk       (clk),
    .rstn      (rstn),
    .ivld      (ivld),
    .idat      (idat),
`ifdef PRBS_CHK_INV_EN
    .iinv      (iinv),
`endif
    .iclr      (iclr),
    .olock     (olock),
    .oerr_beat (oerr_beat),
    .oerr_num  (oerr_num),
    .oerr_cnt  (oerr_cnt)
  );

  always #5 clk = ~clk;

  // serial reference generator: d[n] = d[n-9] ^ d[n-5]
  function automatic logic [63:0] gen_next();
    logic [63:0] r;
    logic        b;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      b    = hist[0] ^ hist[4];
      r[i] = b;
      hist = {b, hist[8:1]};
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic beat(input logic v, input logic [63:0] dat,
                      input logic c);
    ivld = v;
    idat = dat;
    iclr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] g;
    logic [63:0] dat;
    int          errs;
    int          exp_num;
    int          last_num;
    longint      exp_cnt;
    int          pulses;
    int          lost;
    int          nv;

    tv[0]  = '{1, 0, 64'h0000_0000_0002_0000, 0, 1, 1, 1, 1};
    tv[1]  = '{1, 0, 64'h0, 0, 1, 1, 0, 0};
    tv[2]  = '{0, 0, 64'h0, 0, 0, 1, 0, HOLD};
    tv[3]  = '{1, 0, 64'h8000_0000_4000_0001, 1, 1, 1, 1, 3};
    tv[4]  = '{1, 0, 64'h60, 0, 1, 1, 1, 2};
    tv[5]  = '{0, 0, 64'h0, 0, 0, 1, 0, HOLD};
    tv[6]  = '{1, 0, 64'h0, 0, 1, 1, 0, 0};
    tv[7]  = '{1, 1, 64'h0, 0, 1, 1, 1, REF};
    tv[8]  = '{1, 1, 64'h0, 0, 1, 1, 1, REF};
    tv[9]  = '{1, 1, 64'h0, 0, 1, 1, 1, REF};
    tv[10] = '{1, 1, 64'h0, 0, 1, 0, 1, REF};
    tv[11] = '{1, 1, 64'h0, 0, 0, 0, 0, HOLD};
    tv[12] = '{1, 1, 64'h0, 0, 0, 0, 0, HOLD};
    tv[13] = '{1, 1, 64'h0, 0, 0, 0, 0, HOLD};
    tv[14] = '{1, 0, 64'h0, 0, 0, 0, 0, HOLD};
    tv[15] = '{1, 0, 64'h0, 0, 0, 0, 0, HOLD};
    tv[16] = '{1, 0, 64'h0, 0, 0, 0, 0, HOLD};
    tv[17] = '{1, 0, 64'h0, 0, 0, 0, 0, HOLD};
    tv[18] = '{1, 0, 64'h0, 0, 0, 1, 0, HOLD};
    tv[19] = '{1, 1, 64'h0, 0, 1, 1, 1, REF};
    tv[20] = '{1, 1, 64'h0, 0, 1, 1, 1, REF};
    tv[21] = '{1, 1, 64'h0, 0, 1, 1, 1, REF};
    tv[22] = '{1, 0, 64'h0, 0, 1, 1, 0, 0};
    tv[23] = '{1, 1, 64'h0, 0, 1, 1, 1, REF};
    tv[24] = '{1, 1, 64'h0, 0, 1, 1, 1, REF};
    tv[25] = '{1, 0, 64'h7F, 0, 1, 1, 1, 7};
    tv[26] = '{1, 1, 64'h0, 0, 1, 1, 1, REF};
    tv[27] = '{1, 1, 64'h0, 0, 1, 1, 1, REF};
    tv[28] = '{1, 1, 64'h0, 0, 1, 1, 1, REF};
    tv[29] = '{1, 0, 64'hFF00, 0, 1, 0, 1, 8};

    hist = 9'h1FF;
    rstn = 1'b0;
    ivld = 1'b0;
    idat = '0;
    iclr = 1'b0;
`ifdef PRBS_CHK_INV_EN
    iinv = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lock", olock, 0);
    chk("rst_beat", oerr_beat, 0);
    chk("rst_num", oerr_num, 0);
    chk("rst_cnt", oerr_cnt, 0);
    @(negedge clk);
    rstn = 1'b1;

    for (int k = 1; k <= 5; k++) begin
      beat(1'b1, gen_next(), 1'b0);
      chk($sformatf("lock_b%0d", k), olock, k == 5);
    end

    pulses = 0;
    lost   = 0;
    for (int k = 0; k < 1000; k++) begin
      beat(1'b1, gen_next(), 1'b0);
      if (oerr_beat) pulses++;
      if (!olock) lost++;
    end
    chk("clean_cnt", oerr_cnt, 0);
    chk("clean_pulses", pulses, 0);
    chk("clean_lost", lost, 0);

    exp_cnt  = 0;
    last_num = 0;
    for (int i = 0; i < 30; i++) begin
      if (tv[i].vld) begin
        g   = gen_next();
        dat = tv[i].zero ? 64'h0 : (g ^ tv[i].flip);
      end else begin
        g   = '0;
        dat = 64'hDEAD_BEEF_0BAD_F00D;
      end
      errs = tv[i].zero ? $countones(g) : $countones(tv[i].flip);
      beat(tv[i].vld, dat, tv[i].clr);
      if (tv[i].e_num == HOLD) exp_num = last_num;
      else if (tv[i].e_num == REF) exp_num = errs;
      else exp_num = tv[i].e_num;
      last_num = exp_num;
      if (tv[i].clr) exp_cnt = 0;
      else if (tv[i].add) exp_cnt = exp_cnt + longint'(errs);
      chk($sformatf("v%0d_lock", i), olock, tv[i].e_lock);
      chk($sformatf("v%0d_beat", i), oerr_beat, tv[i].e_beat);
      chk($sformatf("v%0d_num", i), oerr_num, exp_num);
      chk($sformatf("v%0d_cnt", i), oerr_cnt, exp_cnt[31:0]);
    end

    for (int k = 1; k <= 5; k++) begin
      beat(1'b1, gen_next(), 1'b0);
    end
    chk("relock", olock, 1);
    force dut.oerr_cnt_q = 32'hFFFF_FFFC;
    #1;
    release dut.oerr_cnt_q;
    chk("preload", oerr_cnt, 32'hFFFF_FFFC);
    beat(1'b1, gen_next() ^ 64'h7, 1'b0);
    chk("sat_exact", oerr_cnt, 32'hFFFF_FFFF);
    beat(1'b1, gen_next() ^ 64'h100, 1'b0);
    chk("sat_hold", oerr_cnt, 32'hFFFF_FFFF);
    force dut.oerr_cnt_q = 32'hFFFF_FFF0;
    #1;
    release dut.oerr_cnt_q;
    g = gen_next();
    beat(1'b1, 64'h0, 1'b0);
    chk("sat_big", oerr_cnt, 32'hFFFF_FFFF);
    chk("sat_lock", olock, 1);

    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_lock", olock, 0);
    chk("mid_rst_beat", oerr_beat, 0);
    chk("mid_rst_num", oerr_num, 0);
    chk("mid_rst_cnt", oerr_cnt, 0);
    @(negedge clk);
    rstn = 1'b1;

    nv = 0;
    for (int c = 0; c < 200 && nv < 8; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        beat(1'b1, gen_next(), 1'b0);
        nv++;
      end else begin
        beat(1'b0, {$urandom, $urandom}, 1'b0);
      end
      chk("rnd_lock", olock, nv >= 5);
      chk("rnd_pulse", oerr_beat, 0);
    end
    chk("rnd_done", nv, 8);
    chk("rnd_cnt", oerr_cnt, 0);

`ifdef PRBS_CHK_INV_EN
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    iinv = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      beat(1'b1, ~gen_next(), 1'b0);
      chk($sformatf("inv_lock%0d", k), olock, k >= 5);
      chk($sformatf("inv_num%0d", k), oerr_num, 0);
    end
    chk("inv_cnt", oerr_cnt, 0);
    iinv = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
